// File: rtl/serial_mmio_slave.sv
`timescale 1ns/1ps
// Purpose : generic synchronous FIFO; head visible combinationally on pop_dat.
// Latency : a pushed entry is visible on pop_dat and in empty/full after one edge.
// Backpress: a push while full is dropped, even if a pop happens in the same cycle;
//            a pop while empty is ignored.
// Ports   : clk/rst, push_vld/push_dat, pop_rdy/pop_dat, full/empty status.
module serial_mmio_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // full/empty come straight from the count register, so they describe the
    // occupancy after the previous edge; a same-cycle pop never makes room.
    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push_vld & ~full;
    assign do_pop  = pop_rdy & ~empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// Purpose : MMIO responder bridging the CPU data bus to a UART rx/tx pair via FIFOs.
// Latency : ack_o one cycle after ce_i is seen in idle; tx_start_o one cycle after pop.
// Backpress: bus never stalls; RX overflow and TX-full writes drop the byte and set
//            sticky flags; TX drains only while tx_busy_i is low.
// Ports   : bus (ce_i/we_i/addr_i/sel_i/data_i -> data_o/ack_o), UART rx (rx_ready_i,
//            rx_data_i), UART tx (tx_busy_i -> tx_start_o/tx_data_o), level irq_o.
module serial_mmio_slave #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic        rx_ready_i,
    input  logic [7:0]  rx_data_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_data_o,
    output logic        irq_o
);
    typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;

    bus_state_t bus_state, bus_next;
    tx_state_t  tx_state, tx_next;

    logic        rx_full, rx_empty, rx_pop;
    logic [7:0]  rx_head;
    logic        tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]  tx_head;
    logic        access;
    logic        status_clr, ctrl_wr, tx_ovf_set, rx_ovr_set;
    logic [31:0] rd_mux;
    logic        rx_ovr, tx_ovf, rx_irq_en;
    logic        tx_wait_first;
    logic        unused_bits;

    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], sel_i[3:1], data_i[31:8]};

    serial_mmio_fifo #(.W(8), .AW(RX_AW)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .push_vld(rx_ready_i), .push_dat(rx_data_i),
        .pop_rdy(rx_pop), .pop_dat(rx_head),
        .full(rx_full), .empty(rx_empty)
    );

    serial_mmio_fifo #(.W(8), .AW(TX_AW)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .push_vld(tx_push), .push_dat(data_i[7:0]),
        .pop_rdy(tx_pop), .pop_dat(tx_head),
        .full(tx_full), .empty(tx_empty)
    );

    // Bus FSM: the access and all its side effects happen on the edge that
    // leaves IDLE; ACK is a fixed one-cycle response that ignores ce_i.
    always_comb begin
        bus_next   = bus_state;
        access     = 1'b0;
        rx_pop     = 1'b0;
        tx_push    = 1'b0;
        status_clr = 1'b0;
        ctrl_wr    = 1'b0;
        rd_mux     = '0;
        case (bus_state)
            BUS_IDLE: begin
                if (ce_i) begin
                    access   = 1'b1;
                    bus_next = BUS_ACK;
                end
            end
            BUS_ACK:  bus_next = BUS_IDLE;
            default:  bus_next = BUS_IDLE;
        endcase
        case (addr_i[3:2])
            2'd0: begin
                rd_mux  = rx_empty ? 32'h0 : {24'h0, rx_head};
                rx_pop  = access & ~we_i & ~rx_empty;
                tx_push = access & we_i & sel_i[0];
            end
            2'd1: begin
                rd_mux     = {28'h0, tx_ovf, rx_ovr, ~rx_empty, ~tx_full};
                status_clr = access & ~we_i;
            end
            2'd2: begin
                rd_mux  = {31'h0, rx_irq_en};
                ctrl_wr = access & we_i;
            end
            default: rd_mux = '0;
        endcase
    end

    assign tx_ovf_set = tx_push & tx_full;
    assign rx_ovr_set = rx_ready_i & rx_full;
    assign ack_o      = (bus_state == BUS_ACK);

    // TX FSM: TX_WAIT skips its first cycle so a transmitter that raises busy
    // one cycle after the start pulse is not mistaken for an idle one.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy_i) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: tx_next = TX_WAIT;
            TX_WAIT: begin
                if (!tx_wait_first && !tx_busy_i) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    assign tx_start_o = (tx_state == TX_START);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state     <= BUS_IDLE;
            tx_state      <= TX_IDLE;
            tx_wait_first <= 1'b0;
            data_o        <= '0;
            tx_data_o     <= '0;
            rx_ovr        <= 1'b0;
            tx_ovf        <= 1'b0;
            rx_irq_en     <= 1'b0;
            irq_o         <= 1'b0;
        end else begin
            bus_state     <= bus_next;
            tx_state      <= tx_next;
            tx_wait_first <= (tx_state == TX_START);
            if (access)  data_o    <= we_i ? 32'h0 : rd_mux;
            if (tx_pop)  tx_data_o <= tx_head;
            if (ctrl_wr) rx_irq_en <= data_i[0];
            // A new overflow in the same cycle as a STATUS read stays visible.
            rx_ovr <= (rx_ovr & ~status_clr) | rx_ovr_set;
            tx_ovf <= (tx_ovf & ~status_clr) | tx_ovf_set;
            irq_o  <= rx_irq_en & ~rx_empty;
        end
    end
endmodule
